// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing control bundle between the front-end pipeline stages and pipeline_ctrl.
// slave = the controller, master = the pipeline stages driving it.
interface pipeline_ctrl_if #(
    parameter int unsigned OUTST_W = 3
);
    logic [8:0]         dec_rs1_in;
    logic [8:0]         dec_rs2_in;
    logic               dec_rs1_read_in;
    logic               dec_rs2_read_in;
    logic               dec_fence_in;
    logic               ex_valid_in;
    logic               ex_rd_write_in;
    logic               ex_mem_read_in;
    logic [8:0]         ex_rd_in;
    logic               mem_valid_in;
    logic               mem_rd_write_in;
    logic [8:0]         mem_rd_in;
    logic               mem_stall_in;
    logic               mem_issue_in;
    logic               mem_done_in;
    logic               mispredict_in;
    logic               fetch_stall_out;
    logic               fetch_flush_out;
    logic               dec_stall_out;
    logic               dec_flush_out;
    logic               fence_busy_out;
    logic [OUTST_W-1:0] outst_count_out;
    logic               outst_err_out;

    modport master (
        output dec_rs1_in, dec_rs2_in, dec_rs1_read_in, dec_rs2_read_in, dec_fence_in,
        output ex_valid_in, ex_rd_write_in, ex_mem_read_in, ex_rd_in,
        output mem_valid_in, mem_rd_write_in, mem_rd_in,
        output mem_stall_in, mem_issue_in, mem_done_in, mispredict_in,
        input  fetch_stall_out, fetch_flush_out, dec_stall_out, dec_flush_out,
        input  fence_busy_out, outst_count_out, outst_err_out
    );

    modport slave (
        input  dec_rs1_in, dec_rs2_in, dec_rs1_read_in, dec_rs2_read_in, dec_fence_in,
        input  ex_valid_in, ex_rd_write_in, ex_mem_read_in, ex_rd_in,
        input  mem_valid_in, mem_rd_write_in, mem_rd_in,
        input  mem_stall_in, mem_issue_in, mem_done_in, mispredict_in,
        output fetch_stall_out, fetch_flush_out, dec_stall_out, dec_flush_out,
        output fence_busy_out, outst_count_out, outst_err_out
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Front-end hazard/sequencing controller: load-use bubbles, mispredict redirect, fence drain.
// Define PIPECTL_FORWARDING_EN when execute-to-execute forwarding exists (only load-use bubbles).
module pipeline_ctrl #(
    parameter int unsigned OUTST_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [OUTST_W-1:0] cnt;
    logic               err;

    logic hz_ex_c;
    logic load_use_c;
    logic hazard_bubble_c;
    logic drain_wait_c;

    // True when a decode source register (never x0) matches the given producer rd.
    function automatic logic src_match(input logic [8:0] rd);
        return ((bus.dec_rs1_read_in && (bus.dec_rs1_in != 9'd0) && (bus.dec_rs1_in == rd)) ||
                (bus.dec_rs2_read_in && (bus.dec_rs2_in != 9'd0) && (bus.dec_rs2_in == rd)));
    endfunction

    assign hz_ex_c    = bus.ex_valid_in && bus.ex_rd_write_in && src_match(bus.ex_rd_in);
    assign load_use_c = hz_ex_c && bus.ex_mem_read_in;

`ifdef PIPECTL_FORWARDING_EN
    assign hazard_bubble_c = load_use_c;
`else
    logic hz_mem_c;
    assign hz_mem_c        = bus.mem_valid_in && bus.mem_rd_write_in && src_match(bus.mem_rd_in);
    assign hazard_bubble_c = hz_ex_c || hz_mem_c;
`endif

    // Fence must wait for every in-flight or in-pipe data-memory access.
    assign drain_wait_c = (cnt != '0) || (bus.ex_valid_in && bus.ex_mem_read_in) || bus.mem_valid_in;

    // Outstanding data-memory op counter with sticky saturation error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (bus.mem_issue_in && !bus.mem_done_in) begin
            if (cnt == CNT_MAX) err <= 1'b1;
            else                cnt <= cnt + OUTST_W'(1);
        end else if (bus.mem_done_in && !bus.mem_issue_in) begin
            if (cnt == '0) err <= 1'b1;
            else           cnt <= cnt - OUTST_W'(1);
        end
    end

    // Fence sequencing; a mispredict discards any fence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (bus.mispredict_in) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:     if (bus.dec_fence_in && !bus.mem_stall_in) state <= ST_DRAIN;
                ST_DRAIN:   if (!drain_wait_c) state <= ST_RELEASE;
                ST_RELEASE: if (!bus.mem_stall_in) state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

    // Prioritised stage controls, combinational from inputs and registered state.
    always_comb begin
        bus.fetch_stall_out = 1'b0;
        bus.fetch_flush_out = 1'b0;
        bus.dec_stall_out   = 1'b0;
        bus.dec_flush_out   = 1'b0;
        if (!rst_n) begin
            bus.fetch_flush_out = 1'b1;
            bus.dec_flush_out   = 1'b1;
        end else if (bus.mem_stall_in) begin
            bus.fetch_stall_out = 1'b1;
            bus.dec_stall_out   = 1'b1;
        end else if (bus.mispredict_in) begin
            bus.fetch_flush_out = 1'b1;
            bus.dec_flush_out   = 1'b1;
        end else if ((state == ST_DRAIN) && drain_wait_c) begin
            bus.fetch_stall_out = 1'b1;
            bus.dec_flush_out   = 1'b1;
        end else if (hazard_bubble_c) begin
            bus.fetch_stall_out = 1'b1;
            bus.dec_flush_out   = 1'b1;
        end
    end

    assign bus.fence_busy_out  = (state != ST_RUN);
    assign bus.outst_count_out = cnt;
    assign bus.outst_err_out   = err;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed test-plan sequences followed by random traffic.
module tb_pipeline_ctrl;
    localparam int unsigned OUTST_W = 3;
    localparam int CNT_MAX = (1 << OUTST_W) - 1;
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_RELEASE = 2;

    typedef struct packed {
        logic               fs;
        logic               ff;
        logic               ds;
        logic               df;
        logic               busy;
        logic [OUTST_W-1:0] cnt;
        logic               err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.OUTST_W(OUTST_W)) bus();
    pipeline_ctrl #(.OUTST_W(OUTST_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    obs_t  exp_q[$];
    string tag_q[$];
    string tag = "init";
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model state
    int m_phase = PH_RUN;
    int m_count = 0;
    bit m_err   = 1'b0;

    task automatic idle();
        bus.dec_rs1_in = '0;      bus.dec_rs2_in = '0;
        bus.dec_rs1_read_in = 0;  bus.dec_rs2_read_in = 0;
        bus.dec_fence_in = 0;
        bus.ex_valid_in = 0;      bus.ex_rd_write_in = 0;
        bus.ex_mem_read_in = 0;   bus.ex_rd_in = '0;
        bus.mem_valid_in = 0;     bus.mem_rd_write_in = 0;
        bus.mem_rd_in = '0;
        bus.mem_stall_in = 0;     bus.mem_issue_in = 0;
        bus.mem_done_in = 0;      bus.mispredict_in = 0;
    endtask

    function automatic bit reads_reg(input logic [8:0] r);
        if (r == 9'd0) return 1'b0;
        return (bus.dec_rs1_read_in && bus.dec_rs1_in == r) || (bus.dec_rs2_read_in && bus.dec_rs2_in == r);
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model across the clock edge.
    task automatic cycle();
        obs_t e;
        bit   pipe_empty, hz;
        int   n;
        if (!rst_n) begin
            m_phase = PH_RUN; m_count = 0; m_err = 1'b0;
        end
        pipe_empty = (m_count == 0) && !(bus.ex_valid_in && bus.ex_mem_read_in) && !bus.mem_valid_in;
        hz = bus.ex_valid_in && bus.ex_rd_write_in && bus.ex_mem_read_in && reads_reg(bus.ex_rd_in);
`ifndef PIPECTL_FORWARDING_EN
        hz = hz || (bus.ex_valid_in && bus.ex_rd_write_in && reads_reg(bus.ex_rd_in))
                || (bus.mem_valid_in && bus.mem_rd_write_in && reads_reg(bus.mem_rd_in));
`endif
        e = '0;
        if (!rst_n)                                begin e.ff = 1; e.df = 1; end
        else if (bus.mem_stall_in)                 begin e.fs = 1; e.ds = 1; end
        else if (bus.mispredict_in)                begin e.ff = 1; e.df = 1; end
        else if (m_phase == PH_DRAIN && !pipe_empty) begin e.fs = 1; e.df = 1; end
        else if (hz)                               begin e.fs = 1; e.df = 1; end
        e.busy = (m_phase != PH_RUN);
        e.cnt  = OUTST_W'(m_count);
        e.err  = m_err;
        exp_q.push_back(e);
        tag_q.push_back(tag);

        @(posedge clk);
        if (rst_n) begin
            n = m_count + int'(bus.mem_issue_in) - int'(bus.mem_done_in);
            if (n < 0)            begin n = 0;       m_err = 1'b1; end
            else if (n > CNT_MAX) begin n = CNT_MAX; m_err = 1'b1; end
            m_count = n;
            if (bus.mispredict_in) m_phase = PH_RUN;
            else if (m_phase == PH_RUN && bus.dec_fence_in && !bus.mem_stall_in) m_phase = PH_DRAIN;
            else if (m_phase == PH_DRAIN && pipe_empty) m_phase = PH_RELEASE;
            else if (m_phase == PH_RELEASE && !bus.mem_stall_in) m_phase = PH_RUN;
        end
        #1;
    endtask

    // Monitor: compare queued expectation against what the DUT presents, away from the edge.
    initial begin
        obs_t  e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {bus.fetch_stall_out, bus.fetch_flush_out, bus.dec_stall_out, bus.dec_flush_out,
                     bus.fence_busy_out, bus.outst_count_out, bus.outst_err_out};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got fs/ff/ds/df=%b%b%b%b busy=%b cnt=%0d err=%b, required fs/ff/ds/df=%b%b%b%b busy=%b cnt=%0d err=%b",
                             t, $time, a.fs, a.ff, a.ds, a.df, a.busy, a.cnt, a.err,
                             e.fs, e.ff, e.ds, e.df, e.busy, e.cnt, e.err);
                end
            end
        end
    end

    function automatic logic [8:0] rnd_reg();
        if ($urandom_range(7) == 0) return 9'($urandom_range(511));
        return 9'($urandom_range(3));
    endfunction

    initial begin
        idle();
        @(posedge clk);
        #1;
        tag = "reset";           cycle(); cycle();
        rst_n = 1'b1;
        tag = "reset_release";   cycle();
        tag = "run_idle";        repeat (2) cycle();
        tag = "mid_run_reset";   bus.mem_issue_in = 1; cycle(); rst_n = 1'b0; cycle();
        rst_n = 1'b1;            idle(); cycle();

        // Load in execute with rd=5, decode reads rs1=5, then rs1=0
        tag = "load_use";
        bus.ex_valid_in = 1; bus.ex_rd_write_in = 1; bus.ex_mem_read_in = 1; bus.ex_rd_in = 9'd5;
        bus.dec_rs1_read_in = 1; bus.dec_rs1_in = 9'd5;
        cycle();
        tag = "load_use_after";  idle(); bus.dec_rs1_read_in = 1; bus.dec_rs1_in = 9'd5; cycle();
        tag = "load_use_x0";
        bus.ex_valid_in = 1; bus.ex_rd_write_in = 1; bus.ex_mem_read_in = 1; bus.ex_rd_in = 9'd0;
        bus.dec_rs1_in = 9'd0;
        cycle();

        // 3 issues, fence, then 3 dones
        idle(); tag = "issue";   bus.mem_issue_in = 1; repeat (3) cycle();
        idle(); tag = "fence_run"; bus.dec_fence_in = 1; cycle();
        tag = "fence_drain";     bus.mem_done_in = 1; repeat (3) cycle();
        bus.mem_done_in = 0;     tag = "fence_empty";  cycle();
        tag = "fence_release";   cycle();
        idle(); tag = "fence_done"; cycle();

        // Issue+done together at count 2, then underflow
        tag = "issue2";          bus.mem_issue_in = 1; repeat (2) cycle();
        tag = "issue_and_done";  bus.mem_done_in = 1; cycle();
        bus.mem_issue_in = 0;    tag = "done";  repeat (2) cycle();
        tag = "underflow";       cycle();
        idle(); tag = "err_sticky"; repeat (2) cycle();

        // Mispredict with load-use and fence
        tag = "mispredict";
        bus.mispredict_in = 1; bus.dec_fence_in = 1;
        bus.ex_valid_in = 1; bus.ex_rd_write_in = 1; bus.ex_mem_read_in = 1; bus.ex_rd_in = 9'd4;
        bus.dec_rs2_read_in = 1; bus.dec_rs2_in = 9'd4;
        cycle();
        idle(); tag = "after_mispredict"; cycle();

        // Memory-stage producer rd=7, decode rs2=7
        tag = "mem_hazard";
        bus.mem_valid_in = 1; bus.mem_rd_write_in = 1; bus.mem_rd_in = 9'd7;
        bus.dec_rs2_read_in = 1; bus.dec_rs2_in = 9'd7;
        cycle();

        // RELEASE held by mem_stall, then reset in the middle of a drain
        idle(); tag = "release_stall";
        bus.dec_fence_in = 1; cycle(); cycle();
        bus.mem_stall_in = 1; repeat (2) cycle();
        bus.mem_stall_in = 0; cycle(); idle(); cycle();
        tag = "reset_mid_drain";
        bus.mem_issue_in = 1; cycle(); bus.mem_issue_in = 0;
        bus.dec_fence_in = 1; repeat (2) cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1; repeat (3) cycle();

        // Randomised traffic
        tag = "random";
        for (int i = 0; i < 3000; i++) begin
            rst_n                = ($urandom_range(99) != 0);
            bus.dec_rs1_in       = rnd_reg();
            bus.dec_rs2_in       = rnd_reg();
            bus.dec_rs1_read_in  = 1'($urandom_range(1));
            bus.dec_rs2_read_in  = 1'($urandom_range(1));
            bus.dec_fence_in     = ($urandom_range(4) == 0);
            bus.ex_valid_in      = 1'($urandom_range(1));
            bus.ex_rd_write_in   = 1'($urandom_range(1));
            bus.ex_mem_read_in   = ($urandom_range(2) == 0);
            bus.ex_rd_in         = rnd_reg();
            bus.mem_valid_in     = ($urandom_range(2) == 0);
            bus.mem_rd_write_in  = 1'($urandom_range(1));
            bus.mem_rd_in        = rnd_reg();
            bus.mem_stall_in     = ($urandom_range(6) == 0);
            bus.mem_issue_in     = ($urandom_range(3) == 0);
            bus.mem_done_in      = ($urandom_range(3) == 0);
            bus.mispredict_in    = ($urandom_range(19) == 0);
            cycle();
        end
        rst_n = 1'b1;
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
